// File: rtl/axi_rd_arbiter.sv
// Round-robin read arbiter: icache/dcache miss engines onto one AXI4 AR/R port.
// Latency: request sampled in IDLE -> arvalid next cycle; R beats forwarded combinationally.
// Backpressure: AR payload held until arready; rready follows the owning cache's data_ready.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   i_r_* / i_ret_* / i_r_data* : icache read request and return interface
//   d_r_* / d_ret_* / d_r_data* : dcache read request and return interface
//   ar*                         : AXI4 read address channel (master side)
//   r*                          : AXI4 read data channel (master side); rid/rresp unused
module axi_rd_arbiter (
  input  logic        clk,
  input  logic        rst,
  // icache
  input  logic        i_r_req,
  input  logic [31:0] i_r_addr,
  input  logic [2:0]  i_r_size,
  input  logic [7:0]  i_r_length,
  output logic        i_r_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_r_data,
  input  logic        i_r_data_ready,
  // dcache
  input  logic        d_r_req,
  input  logic [31:0] d_r_addr,
  input  logic [2:0]  d_r_size,
  input  logic [7:0]  d_r_length,
  output logic        d_r_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_r_data,
  input  logic        d_r_data_ready,
  // AXI4 AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI4 R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_owner;       // 0 = icache, 1 = dcache
  logic        r_last_grant;  // client granted most recently
  logic [31:0] r_araddr;
  logic [7:0]  r_arlen;
  logic [2:0]  r_arsize;
  logic [3:0]  r_arid;

  logic        w_any_req;
  logic        w_grant_d;
  logic        w_rready;

  // Steering is by owner only; ID and response code are not consulted.
  logic        w_unused;
  assign w_unused = ^{rid, rresp};

  assign w_any_req = i_r_req | d_r_req;
  // dcache wins if it is the sole requester, or on a tie when it was not last served.
  assign w_grant_d = d_r_req & (~i_r_req | ~r_last_grant);

  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arsize  = r_arsize;
  assign arid    = r_arid;
  assign arburst = 2'b01;
  assign rready  = w_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    arvalid      = 1'b0;
    w_rready     = 1'b0;
    i_r_rdy      = 1'b0;
    d_r_rdy      = 1'b0;
    i_ret_valid  = 1'b0;
    i_ret_last   = 1'b0;
    i_r_data     = 32'd0;
    d_ret_valid  = 1'b0;
    d_ret_last   = 1'b0;
    d_r_data     = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = S_ADDR;
        end
      end
      S_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          d_r_rdy      = r_owner;
          i_r_rdy      = ~r_owner;
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        w_rready = r_owner ? d_r_data_ready : i_r_data_ready;
        if (r_owner) begin
          d_ret_valid = rvalid;
          d_ret_last  = rlast;
          d_r_data    = rdata;
        end else begin
          i_ret_valid = rvalid;
          i_ret_last  = rlast;
          i_r_data    = rdata;
        end
        if (rvalid && w_rready && rlast) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Grant bookkeeping and AR payload; only loaded when a grant is made in IDLE,
  // so the payload stays frozen through ADDR and DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b0;
      r_araddr     <= 32'd0;
      r_arlen      <= 8'd0;
      r_arsize     <= 3'd0;
      r_arid       <= 4'd0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_owner      <= w_grant_d;
      r_last_grant <= w_grant_d;
      r_araddr     <= w_grant_d ? d_r_addr   : i_r_addr;
      r_arlen      <= w_grant_d ? d_r_length : i_r_length;
      r_arsize     <= w_grant_d ? d_r_size   : i_r_size;
      r_arid       <= {3'd0, w_grant_d};
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed table of transactions, reset-mid-burst
// sequence, then randomized transactions against a round-robin grant model.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        i_r_req, d_r_req;
  logic [31:0] i_r_addr, d_r_addr;
  logic [2:0]  i_r_size, d_r_size;
  logic [7:0]  i_r_length, d_r_length;
  logic        i_r_rdy, d_r_rdy;
  logic        i_ret_valid, d_ret_valid;
  logic        i_ret_last, d_ret_last;
  logic [31:0] i_r_data, d_r_data;
  logic        i_r_data_ready, d_r_data_ready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .i_r_req(i_r_req), .i_r_addr(i_r_addr), .i_r_size(i_r_size), .i_r_length(i_r_length),
    .i_r_rdy(i_r_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
    .i_r_data(i_r_data), .i_r_data_ready(i_r_data_ready),
    .d_r_req(d_r_req), .d_r_addr(d_r_addr), .d_r_size(d_r_size), .d_r_length(d_r_length),
    .d_r_rdy(d_r_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
    .d_r_data(d_r_data), .d_r_data_ready(d_r_data_ready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  logic model_last;  // client served most recently (1 = dcache)

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic [31:0] ia;
    logic [31:0] da;
    logic [7:0]  il;
    logic [7:0]  dl;
    logic [2:0]  isz;
    logic [2:0]  dsz;
    int          ar_wait;
    int          rdy_mode;  // 0 always ready, 1 alternate 1,0,1.., 2 random
    logic        keep;      // keep requests asserted after the handshake
    logic        exp_own;   // expected winner (1 = dcache)
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Round-robin rule: sole requester wins; on a tie the client not served last wins.
  function automatic logic pick(input logic ir, input logic dq, input logic last);
    if (ir && !dq) return 1'b0;
    if (dq && !ir) return 1'b1;
    return ~last;
  endfunction

  // Entered and left mid-cycle with the DUT in IDLE. Requests driven on entry are
  // sampled at the next edge, so arvalid must be high in the very next cycle.
  task automatic run_txn(input logic ireq, input logic dreq,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [7:0] il, input logic [7:0] dl,
                         input logic [2:0] isz, input logic [2:0] dsz,
                         input int ar_wait, input int rdy_mode, input logic rnd,
                         input logic keep, input logic exp_own, input int abort_after);
    logic [31:0] ea;
    logic [7:0]  el;
    logic [2:0]  es;
    logic        rv, dr, lst;
    logic [31:0] dat;
    int          b, g;
    i_r_req = ireq; d_r_req = dreq;
    i_r_addr = ia; d_r_addr = da; i_r_length = il; d_r_length = dl;
    i_r_size = isz; d_r_size = dsz;
    arready = 1'b0;
    ea = exp_own ? da : ia;
    el = exp_own ? dl : il;
    es = exp_own ? dsz : isz;
    for (int w = 0; w <= ar_wait; w++) begin
      @(posedge clk); #2;
      arready = (w == ar_wait);
      #2;
      chk("arvalid", 32'(arvalid), 32'd1);
      chk("arid", 32'(arid), 32'(exp_own));
      chk("araddr", araddr, ea);
      chk("arlen", 32'(arlen), 32'(el));
      chk("arsize", 32'(arsize), 32'(es));
      chk("arburst", 32'(arburst), 32'd1);
      chk("d_r_rdy", 32'(d_r_rdy), 32'(arready & exp_own));
      chk("i_r_rdy", 32'(i_r_rdy), 32'(arready & ~exp_own));
    end
    if (!keep) begin
      i_r_req = 1'b0; d_r_req = 1'b0;
      i_r_addr = 32'hFFFF_FFFF; d_r_addr = 32'hFFFF_FFFF;
    end
    b = 0; g = 0;
    while (b <= int'(el) && g < 400 && !(abort_after > 0 && b == abort_after)) begin
      @(posedge clk); #2;
      arready = 1'b0;
      rv  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (rdy_mode)
        0:       dr = 1'b1;
        1:       dr = (g % 2 == 0);
        default: dr = 1'($urandom_range(0, 1));
      endcase
      dat = rnd ? $urandom : 32'(b);
      lst = (b == int'(el));
      rvalid = rv; rdata = dat; rlast = lst; rid = 4'($urandom); rresp = 2'($urandom);
      if (exp_own) begin
        d_r_data_ready = dr; i_r_data_ready = 1'($urandom_range(0, 1));
      end else begin
        i_r_data_ready = dr; d_r_data_ready = 1'($urandom_range(0, 1));
      end
      #2;
      chk("rready", 32'(rready), 32'(dr));
      chk("arvalid_data", 32'(arvalid), 32'd0);
      if (exp_own) begin
        chk("d_ret_valid", 32'(d_ret_valid), 32'(rv));
        chk("d_ret_last", 32'(d_ret_last), 32'(lst));
        chk("d_r_data", d_r_data, dat);
        chk("i_ret_valid_off", 32'(i_ret_valid), 32'd0);
        chk("i_r_data_off", i_r_data, 32'd0);
      end else begin
        chk("i_ret_valid", 32'(i_ret_valid), 32'(rv));
        chk("i_ret_last", 32'(i_ret_last), 32'(lst));
        chk("i_r_data", i_r_data, dat);
        chk("d_ret_valid_off", 32'(d_ret_valid), 32'd0);
        chk("d_r_data_off", d_r_data, 32'd0);
      end
      if (rv && dr) b++;
      g++;
    end
    if (g >= 400) chk("beat_timeout", 32'(g), 32'd0);
    if (abort_after == 0) begin
      @(posedge clk); #2;
      rvalid = 1'b0; rlast = 1'b0;
      #2;
      chk("idle_arvalid", 32'(arvalid), 32'd0);
      chk("idle_rready", 32'(rready), 32'd0);
      chk("idle_i_ret_valid", 32'(i_ret_valid), 32'd0);
      chk("idle_d_ret_valid", 32'(d_ret_valid), 32'd0);
    end
    model_last = exp_own;
  endtask

  logic [1:0] pat;
  logic       ex;

  initial begin
    //         ireq  dreq  ia            da            il     dl     isz   dsz  wait mode keep own
    tbl[0] = '{1'b1, 1'b1, 32'h0000_1000, 32'h2000_0100, 8'd3,  8'd3,  3'd2, 3'd2, 1, 0, 1'b1, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_1000, 32'h2000_0100, 8'd3,  8'd3,  3'd2, 3'd2, 0, 0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_2000, 32'h2000_0200, 8'd1,  8'd2,  3'd2, 3'd1, 0, 0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_2000, 32'h2000_0200, 8'd1,  8'd2,  3'd2, 3'd1, 0, 0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_2000, 32'h2000_0200, 8'd1,  8'd2,  3'd2, 3'd1, 0, 0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_2000, 32'h2000_0200, 8'd1,  8'd2,  3'd2, 3'd1, 0, 0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h0,         32'h3000_0080, 8'd0,  8'd3,  3'd0, 3'd2, 3, 1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 32'h4000_0004, 32'h0,         8'd0,  8'd0,  3'd2, 3'd0, 0, 0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 32'h0,         32'h1C00_0040, 8'd0,  8'd15, 3'd0, 3'd2, 0, 0, 1'b0, 1'b1};

    rst = 1'b1;
    i_r_req = 0; d_r_req = 0; i_r_addr = 0; d_r_addr = 0; i_r_size = 0; d_r_size = 0;
    i_r_length = 0; d_r_length = 0; i_r_data_ready = 0; d_r_data_ready = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    model_last = 1'b0;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    chk("rst_arsize", 32'(arsize), 32'd0);
    chk("rst_arid", 32'(arid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_rdy", 32'({i_r_rdy, d_r_rdy}), 32'd0);
    chk("rst_ret_valid", 32'({i_ret_valid, d_ret_valid}), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      run_txn(tbl[k].ireq, tbl[k].dreq, tbl[k].ia, tbl[k].da, tbl[k].il, tbl[k].dl,
              tbl[k].isz, tbl[k].dsz, tbl[k].ar_wait, tbl[k].rdy_mode, 1'b0,
              tbl[k].keep, tbl[k].exp_own, 0);
    end

    // Reset in the middle of a 16-beat dcache burst, after the 5th beat.
    run_txn(1'b0, 1'b1, 32'h0, 32'h5000_0000, 8'd0, 8'd15, 3'd0, 3'd2, 0, 0, 1'b0, 1'b0, 1'b1, 5);
    @(posedge clk); #2;
    rst = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b0; d_r_data_ready = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #2;
    chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
    chk("mid_rst_rready", 32'(rready), 32'd0);
    chk("mid_rst_d_ret_valid", 32'(d_ret_valid), 32'd0);
    chk("mid_rst_i_ret_valid", 32'(i_ret_valid), 32'd0);
    chk("mid_rst_d_r_data", d_r_data, 32'd0);
    chk("mid_rst_araddr", araddr, 32'd0);
    rvalid = 1'b0;
    model_last = 1'b0;
    run_txn(1'b1, 1'b0, 32'h6000_0010, 32'h0, 8'd7, 8'd0, 3'd2, 3'd0, 0, 0, 1'b0, 1'b0, 1'b0, 0);

    // Randomized transactions; winner predicted by the round-robin model.
    for (int k = 0; k < 40; k++) begin
      pat = 2'($urandom_range(1, 3));
      ex  = pick(pat[0], pat[1], model_last);
      run_txn(pat[0], pat[1], $urandom, $urandom, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
              3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)), $urandom_range(0, 3), 2, 1'b1,
              1'b0, ex, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
